// File: rtl/objbuf_pkg.sv
// Shared definitions for the double-banked object line buffer.
package objbuf_pkg;

    localparam int unsigned PAIR_AW_DEFAULT = 8;
    localparam logic [3:0]  TRANSP_DEFAULT  = 4'h0;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    function automatic logic is_opaque(input logic [7:0] px, input logic [3:0] transp);
        return px[3:0] != transp;
    endfunction

endpackage

// File: rtl/objbuf_bank_ram.sv
// One line-buffer bank: 16-bit words {even byte, odd byte}, byte-write, async read.
module objbuf_bank_ram
    import objbuf_pkg::*;
#(
    parameter int unsigned AW = PAIR_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          we_even,
    input  logic          we_odd,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_even) mem_q[waddr][15:8] <= wdata[15:8];
        if (we_odd)  mem_q[waddr][7:0]  <= wdata[7:0];
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/obj_linebuffer_writer.sv
// Object line buffer: draws pixel pairs into one bank while the scan reads and
// clears the other; banks swap on the line-boundary pulse.
module obj_linebuffer_writer
    import objbuf_pkg::*;
#(
    parameter int unsigned PAIR_AW     = PAIR_AW_DEFAULT,
    parameter logic [3:0]  TRANSP_CODE = TRANSP_DEFAULT
) (
    input  logic               i_EMU_MCLK,
    input  logic               i_EMU_MRST_n,
    input  logic               i_EMU_CLK6MPCEN_n,
    input  logic [7:0]         i_DA,
    input  logic [7:0]         i_DB,
    input  logic [PAIR_AW-1:0] i_WRADDR,
    input  logic               i_WR_n,
    input  logic [PAIR_AW:0]   i_RDADDR,
    input  logic               i_RD_EN,
    input  logic               i_LINESWAP,
    output logic [7:0]         o_PIXEL,
    output logic               o_BANK,
    output logic               o_READY
);

    state_e             state_q, state_d;
    logic [PAIR_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic               bank_q, bank_d;
    logic [7:0]         pixel_q, pixel_d;
    logic               ready_q, ready_d;

    logic               en;
    logic               wr_bank;
    logic [PAIR_AW-1:0] rd_pair;
    logic [15:0]        rd_word;
    logic [1:0]         we_even, we_odd;
    logic [PAIR_AW-1:0] waddr [2];
    logic [15:0]        wdata [2];
    logic [15:0]        rdata [2];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        bank_d    = bank_q;
        pixel_d   = pixel_q;
        ready_d   = ready_q;

        en       = ~i_EMU_CLK6MPCEN_n;
        wr_bank  = ~bank_q;
        rd_pair  = i_RDADDR[PAIR_AW:1];
        rd_word  = bank_q ? rdata[1] : rdata[0];
        we_even  = '0;
        we_odd   = '0;
        waddr[0] = i_WRADDR;
        waddr[1] = i_WRADDR;
        wdata[0] = {i_DA, i_DB};
        wdata[1] = {i_DA, i_DB};

        case (state_q)
            ST_INIT: begin
                if (en) begin
                    we_even   = '1;
                    we_odd    = '1;
                    waddr[0]  = clr_cnt_q;
                    waddr[1]  = clr_cnt_q;
                    wdata[0]  = '0;
                    wdata[1]  = '0;
                    pixel_d   = '0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (!i_WR_n) begin
                        we_even[wr_bank] = is_opaque(i_DA, TRANSP_CODE);
                        we_odd[wr_bank]  = is_opaque(i_DB, TRANSP_CODE);
                    end
                    // The scan bank's write port is free, so it carries the clear-behind-beam.
                    if (i_RD_EN) begin
                        pixel_d = i_RDADDR[0] ? rd_word[7:0] : rd_word[15:8];
                        if (i_RDADDR[0]) begin
                            we_even[bank_q] = 1'b1;
                            we_odd[bank_q]  = 1'b1;
                            waddr[bank_q]   = rd_pair;
                            wdata[bank_q]   = '0;
                        end
                    end else begin
                        pixel_d = '0;
                    end
                    if (i_LINESWAP) bank_d = ~bank_q;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
        if (!i_EMU_MRST_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            bank_q    <= 1'b0;
            pixel_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            bank_q    <= bank_d;
            pixel_q   <= pixel_d;
            ready_q   <= ready_d;
        end
    end

    objbuf_bank_ram #(.AW(PAIR_AW)) u_bank0 (
        .clk     (i_EMU_MCLK),
        .we_even (we_even[0]),
        .we_odd  (we_odd[0]),
        .waddr   (waddr[0]),
        .wdata   (wdata[0]),
        .raddr   (rd_pair),
        .rdata   (rdata[0])
    );

    objbuf_bank_ram #(.AW(PAIR_AW)) u_bank1 (
        .clk     (i_EMU_MCLK),
        .we_even (we_even[1]),
        .we_odd  (we_odd[1]),
        .waddr   (waddr[1]),
        .wdata   (wdata[1]),
        .raddr   (rd_pair),
        .rdata   (rdata[1])
    );

    assign o_PIXEL = pixel_q;
    assign o_BANK  = bank_q;
    assign o_READY = ready_q;

endmodule

// File: tb/tb_obj_linebuffer_writer.sv
// Self-checking bench: directed steps plus random traffic against a per-pixel model.
module tb_obj_linebuffer_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen_n;
    logic [7:0] da, db;
    logic [7:0] wraddr;
    logic       wr_n;
    logic [8:0] rdaddr;
    logic       rd_en;
    logic       lineswap;
    logic [7:0] o_pixel;
    logic       o_bank;
    logic       o_ready;

    int compared   = 0;
    int mismatched = 0;

    // Model: one byte per screen pixel x in each bank.
    logic [7:0] m_mem [2][512];
    int         m_bank;
    int         m_cnt;
    logic       m_ready;
    logic [7:0] m_pix;

    obj_linebuffer_writer #(.PAIR_AW(8), .TRANSP_CODE(4'h0)) dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_MRST_n      (rst_n),
        .i_EMU_CLK6MPCEN_n (cen_n),
        .i_DA              (da),
        .i_DB              (db),
        .i_WRADDR          (wraddr),
        .i_WR_n            (wr_n),
        .i_RDADDR          (rdaddr),
        .i_RD_EN           (rd_en),
        .i_LINESWAP        (lineswap),
        .o_PIXEL           (o_pixel),
        .o_BANK            (o_bank),
        .o_READY           (o_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bank  = 0;
        m_cnt   = 0;
        m_ready = 1'b0;
        m_pix   = 8'h00;
        for (int b = 0; b < 2; b++)
            for (int x = 0; x < 512; x++) m_mem[b][x] = 8'h00;
    endtask

    task automatic model_step(input logic en, input logic wr, input logic rd, input logic sw,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] wa, input logic [8:0] ra);
        int x;
        if (!en) return;
        if (!m_ready) begin
            m_pix = 8'h00;
            m_cnt++;
            if (m_cnt == 256) m_ready = 1'b1;
            return;
        end
        x = int'(ra);
        if (rd) begin
            m_pix = m_mem[m_bank][x];
            if (x % 2 == 1) begin
                m_mem[m_bank][x]     = 8'h00;
                m_mem[m_bank][x - 1] = 8'h00;
            end
        end else begin
            m_pix = 8'h00;
        end
        if (wr) begin
            if (a[3:0] != 4'h0) m_mem[1 - m_bank][2 * int'(wa)]     = a;
            if (b[3:0] != 4'h0) m_mem[1 - m_bank][2 * int'(wa) + 1] = b;
        end
        if (sw) m_bank = 1 - m_bank;
    endtask

    task automatic step(input logic en, input logic wr, input logic rd, input logic sw,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] wa, input logic [8:0] ra);
        cen_n    = ~en;
        wr_n     = ~wr;
        rd_en    = rd;
        lineswap = sw;
        da       = a;
        db       = b;
        wraddr   = wa;
        rdaddr   = ra;
        @(posedge clk);
        model_step(en, wr, rd, sw, a, b, wa, ra);
        #1;
        check("pixel", o_pixel, m_pix);
        check("bank", {7'd0, o_bank}, 8'(m_bank));
        check("ready", {7'd0, o_ready}, {7'd0, m_ready});
    endtask

    function automatic logic [7:0] rand_px();
        logic [3:0] pal;
        logic [3:0] pix;
        pal = 4'($urandom_range(0, 15));
        pix = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(1, 15));
        return {pal, pix};
    endfunction

    task automatic rand_step(input int en_pct, input int sw_pct);
        logic       en, wr, rd, sw;
        logic [7:0] wa;
        logic [8:0] ra;
        en = ($urandom_range(0, 99) < en_pct);
        wr = $urandom_range(0, 1) == 1;
        rd = $urandom_range(0, 3) != 0;
        sw = ($urandom_range(0, 99) < sw_pct);
        wa = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        ra = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 31));
        step(en, wr, rd, sw, rand_px(), rand_px(), wa, ra);
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_ready"}, {7'd0, o_ready}, 8'h00);
        check({tag, "_bank"}, {7'd0, o_bank}, 8'h00);
        check({tag, "_pixel"}, o_pixel, 8'h00);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n_en;
        bit seen;
        rst_n = 1'b0; cen_n = 1'b1; da = '0; db = '0; wraddr = '0; wr_n = 1'b1;
        rdaddr = '0; rd_en = 1'b0; lineswap = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {7'd0, o_ready}, 8'h00);
        check("rst_bank", {7'd0, o_bank}, 8'h00);
        check("rst_pixel", o_pixel, 8'h00);
        rst_n = 1'b1;

        // Power-up clear with random traffic and gaps; ready must rise exactly at 256 enabled cycles.
        for (int i = 0; i < 2000 && !m_ready; i++) rand_step(75, 30);
        check("init_done", {7'd0, o_ready}, 8'h01);
        for (int x = 0; x < 512; x++) step(1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 9'(x));

        // Transparent odd byte skipped; odd read clears the pair.
        step(1, 1, 0, 0, 8'h37, 8'h20, 8'd5, 9'd0);
        step(1, 0, 0, 1, 8'h00, 8'h00, 8'd0, 9'd0);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd10);
        check("a_x10", o_pixel, 8'h37);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd11);
        check("a_x11", o_pixel, 8'h00);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd10);
        check("a_x10_cleared", o_pixel, 8'h00);

        // Last opaque write wins per byte.
        step(1, 1, 0, 0, 8'h15, 8'h16, 8'd9, 9'd0);
        step(1, 1, 0, 0, 8'h20, 8'h4A, 8'd9, 9'd0);
        step(1, 0, 0, 1, 8'h00, 8'h00, 8'd0, 9'd0);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd18);
        check("b_x18", o_pixel, 8'h15);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd19);
        check("b_x19", o_pixel, 8'h4A);

        // Swap, write and read in one cycle use the pre-swap banks.
        step(1, 1, 0, 0, 8'h5C, 8'h00, 8'd3, 9'd0);
        step(1, 0, 0, 1, 8'h00, 8'h00, 8'd0, 9'd0);
        step(1, 1, 1, 1, 8'h11, 8'h00, 8'd3, 9'd6);
        check("c_old_bank", o_pixel, 8'h5C);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd6);
        check("c_new_bank", o_pixel, 8'h11);

        for (int i = 0; i < 1500; i++) rand_step(80, 5);

        // Disabled cycles hold everything.
        step(1, 1, 0, 0, 8'h9A, 8'h00, 8'd7, 9'd0);
        step(1, 0, 0, 1, 8'h00, 8'h00, 8'd0, 9'd0);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd14);
        for (int i = 0; i < 10; i++) begin
            step(0, 1'(i % 2), 1'((i + 1) % 2), 1'(i % 3 == 0), 8'hFF, 8'hEE, 8'd7, 9'(14 + i % 2));
        end
        check("hold_pixel", o_pixel, 8'h9A);
        step(1, 0, 1, 0, 8'h00, 8'h00, 8'd0, 9'd14);
        check("hold_ram", o_pixel, 8'h9A);

        // Reset from RUN with bank 1, then abort a clear partway and restart it.
        if (m_bank == 0) step(1, 0, 0, 1, 8'h00, 8'h00, 8'd0, 9'd0);
        async_reset_check("rst_run");
        for (int i = 0; i < 100; i++) step(1, 0, 1, 1, 8'h00, 8'h00, 8'd0, 9'(i));
        async_reset_check("rst_init100");
        n_en = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            rand_step(70, 20);
            if (cen_n == 1'b0) n_en++;
            if (o_ready) seen = 1'b1;
        end
        compared++;
        assert (seen && n_en == 256) else begin
            mismatched++;
            $error("FAIL init_len: observed %0d enabled cycles (ready=%0b) expected 256", n_en, seen);
        end
        for (int i = 0; i < 300; i++) rand_step(80, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
